pong_game_ctrl: RTL

Game-sequencing controller for the single-player paddle/ball pixel datapath.
It runs the game-phase FSM (IDLE, SERVE, PLAY, OVER) and counts frames for the serve and game-over delays.
It keeps score, lives and the hit-driven speed level.
It drives hold, enable and speed controls into the pixel datapath, which reports paddle hits and right-edge misses back as single-cycle pulses.

---
 rtl/pong_game_ctrl_if.sv | 26 ++
 rtl/pong_game_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and the pixel datapath / front panel.
interface pong_game_ctrl_if;
    // No valid/ready here: frame_tick, hit and miss are one-clk pulses sampled on every clk edge,
    // start is a level, and every controller output is a level that is valid on every cycle.
    logic        frame_tick;
    logic        start;
    logic        hit;
    logic        miss;
    logic        ball_hold;
    logic        play_en;
    logic [3:0]  ball_speed;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        game_over;
    logic [1:0]  state;

    modport master (
        output frame_tick, start, hit, miss,
        input  ball_hold, play_en, ball_speed, score, lives, game_over, state
    );

    modport slave (
        input  frame_tick, start, hit, miss,
        output ball_hold, play_en, ball_speed, score, lives, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Game-phase sequencer for the paddle/ball datapath: serve/over frame delays, score, lives and speed level.
module pong_game_ctrl #(
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int OVER_FRAMES    = 120,
    parameter int HITS_PER_LEVEL = 5,
    parameter int MAX_LEVEL      = 3,
    parameter int BASE_SPEED     = 2
) (
    input  logic           clk,
    input  logic           reset,
    pong_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
    localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
    localparam logic [2:0] LEVEL_TOP  = 3'(MAX_LEVEL);

    state_t      state_q, state_d;
    logic [7:0]  frame_q, frame_d;
    logic [2:0]  level_q, level_d;
    logic [3:0]  hit_q, hit_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        start_q;
    logic        start_rise;

    assign start_rise = bus.start & ~start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            level_q <= '0;
            hit_q   <= '0;
            score_q <= '0;
            lives_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            level_q <= level_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            lives_q <= lives_d;
            start_q <= bus.start;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        level_d = level_q;
        hit_d   = hit_q;
        score_d = score_q;
        lives_d = lives_q;
        case (state_q)
            IDLE: begin
                frame_d = '0;
                if (start_rise) begin
                    state_d = SERVE;
                    lives_d = 2'(LIVES);
                    score_d = '0;
                    level_d = '0;
                    hit_d   = '0;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_q == SERVE_LAST) begin
                        state_d = PLAY;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                frame_d = '0;
                // A miss in the same cycle as a hit discards the hit.
                if (bus.miss) begin
                    lives_d = lives_q - 2'd1;
                    level_d = '0;
                    hit_d   = '0;
                    state_d = (lives_q == 2'd1) ? OVER : SERVE;
                end else if (bus.hit) begin
                    if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    if (hit_q == HIT_LAST) begin
                        hit_d = '0;
                        if (level_q != LEVEL_TOP) level_d = level_q + 3'd1;
                    end else begin
                        hit_d = hit_q + 4'd1;
                    end
                end
            end
            OVER: begin
                if (bus.frame_tick) begin
                    if (frame_q == OVER_LAST) begin
                        state_d = IDLE;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.ball_hold  = (state_q != PLAY);
    assign bus.play_en    = (state_q == PLAY);
    assign bus.game_over  = (state_q == OVER);
    assign bus.ball_speed = 4'(BASE_SPEED) + {1'b0, level_q};
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
endmodule
